// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32 pipeline control logic: forwarding-mux
// selects, the ResultSrc code that marks a load, and the memory-wait FSM states.
package riscv_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding select for one E-stage source operand. The M-stage ALU result
// is newer than the W-stage result, so M wins when both match. x0 is never
// forwarded because writes to it are discarded.
module hazard_fwd_unit
  import riscv_pkg::*;
(
  input  logic [4:0] RsE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] Forward
);

  // Priority select: M result, then W result, else register file.
  always_comb begin
    Forward = FWD_RF;
    if (RegWriteM && (RdM != 5'd0) && (RdM == RsE))
      Forward = FWD_M;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE))
      Forward = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline scheduler for the 5-stage RV32 core: load-use stalls, branch/jump
// redirect flushes, data-memory wait stalls with a timeout, E-stage
// forwarding, and stall/flush performance counters.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             DmemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             PCSrcGate,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // wait_cnt never exceeds MEM_TIMEOUT-1, so clog2 bits suffice.
  localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  mem_state_t      state, state_next;
  logic [WC_W-1:0] wait_cnt, wait_next;
  logic            mem_stall;
  logic            lw_stall;
  logic            gate;

  hazard_fwd_unit u_fwd_a (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Forward   (ForwardAE)
  );

  hazard_fwd_unit u_fwd_b (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Forward   (ForwardBE)
  );

  // Memory-wait FSM: Mealy stall plus next state and timeout count.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    mem_stall  = 1'b0;
    case (state)
      ST_RUN: begin
        mem_stall = MemReqM & ~DmemReadyM;
        if (mem_stall) begin
          state_next = ST_WAIT;
          wait_next  = WC_W'(1);
        end
      end
      ST_WAIT: begin
        mem_stall = ~DmemReadyM;
        if (DmemReadyM) begin
          state_next = ST_RUN;
          wait_next  = '0;
        end else if (wait_cnt == WC_LAST) begin
          state_next = ST_ERR;
        end else begin
          wait_next = wait_cnt + WC_W'(1);
        end
      end
      ST_ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_next = ST_RUN;
        wait_next  = '0;
      end
    endcase
  end

  // Stall/flush decode; everything is held inactive while in reset.
  // During a mem stall E is frozen (never cleared) and any redirect waits.
  always_comb begin
    lw_stall  = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                ((RdE == Rs1D) || (RdE == Rs2D));
    gate      = PCSrcE & ~mem_stall;
    StallF    = rst_n & (lw_stall | mem_stall);
    StallD    = rst_n & (lw_stall | mem_stall);
    StallE    = rst_n & mem_stall;
    StallM    = rst_n & mem_stall;
    FlushW    = rst_n & mem_stall;
    PCSrcGate = rst_n & gate;
    FlushD    = rst_n & gate;
    FlushE    = rst_n & (lw_stall | gate) & ~mem_stall;
  end

  // FSM state, timeout count and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (state_next == ST_ERR)
        mem_err <= 1'b1;
    end
  end

  // Performance counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(StallF);
      flush_cnt <= flush_cnt + CNT_W'(FlushD);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a cycle-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_hazard_ctrl;

  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, DmemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, PCSrcGate;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .DmemReadyM(DmemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .PCSrcGate(PCSrcGate),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory wait tracked as a count of consecutive stalled
  // cycles; reaching MT stalled cycles means the access has timed out.
  int          m_wait = 0;
  bit          m_err  = 1'b0;
  logic [31:0] m_scnt = 0;
  logic [31:0] m_fcnt = 0;
  bit          armed  = 1'b0;

  function automatic logic [1:0] f_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic f_ms();
    if (m_err) return 1'b1;
    if (m_wait != 0) return ~DmemReadyM;
    return MemReqM & ~DmemReadyM;
  endfunction

  function automatic logic f_lw();
    return (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_wait <= 0;
      m_err  <= 1'b0;
      m_scnt <= 0;
      m_fcnt <= 0;
      armed  <= 1'b1;
    end else begin
      m_scnt <= m_scnt + {31'b0, f_lw() | f_ms()};
      m_fcnt <= m_fcnt + {31'b0, PCSrcE & ~f_ms()};
      if (!m_err) begin
        if (f_ms()) begin
          m_wait <= m_wait + 1;
          if (m_wait + 1 == MT) m_err <= 1'b1;
        end else begin
          m_wait <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_StallF",    {31'b0, StallF},    {31'b0, rst_n & (f_lw() | f_ms())});
      chk("m_StallD",    {31'b0, StallD},    {31'b0, rst_n & (f_lw() | f_ms())});
      chk("m_StallE",    {31'b0, StallE},    {31'b0, rst_n & f_ms()});
      chk("m_StallM",    {31'b0, StallM},    {31'b0, rst_n & f_ms()});
      chk("m_FlushW",    {31'b0, FlushW},    {31'b0, rst_n & f_ms()});
      chk("m_PCSrcGate", {31'b0, PCSrcGate}, {31'b0, rst_n & PCSrcE & ~f_ms()});
      chk("m_FlushD",    {31'b0, FlushD},    {31'b0, rst_n & PCSrcE & ~f_ms()});
      chk("m_FlushE",    {31'b0, FlushE},    {31'b0, rst_n & (f_lw() | PCSrcE) & ~f_ms()});
      chk("m_ForwardAE", {30'b0, ForwardAE}, {30'b0, f_fwd(Rs1E)});
      chk("m_ForwardBE", {30'b0, ForwardBE}, {30'b0, f_fwd(Rs2E)});
      chk("m_mem_err",   {31'b0, mem_err},   {31'b0, m_err});
      chk("m_stall_cnt", stall_cnt, m_scnt);
      chk("m_flush_cnt", flush_cnt, m_fcnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00;
    {RegWriteM, RegWriteW, PCSrcE, MemReqM, DmemReadyM} = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state and forwarding priority
    @(negedge clk);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_mem_err", {31'b0, mem_err}, 32'd0);
    Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    #1 chk("fwd_m_prio", {30'b0, ForwardAE}, 32'd2);
    chk("fwd_b_m", {30'b0, ForwardBE}, 32'd2);
    RegWriteM = 0;
    #1 chk("fwd_w", {30'b0, ForwardAE}, 32'd1);
    RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0;
    #1 chk("fwd_x0", {30'b0, ForwardAE}, 32'd0);
    tick();
    {Rs1E, Rs2E, RdM, RdW, RegWriteM, RegWriteW} = '0;

    // Load-use stall
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    @(negedge clk);
    chk("lw_StallF", {31'b0, StallF}, 32'd1);
    chk("lw_StallD", {31'b0, StallD}, 32'd1);
    chk("lw_FlushE", {31'b0, FlushE}, 32'd1);
    chk("lw_StallE", {31'b0, StallE}, 32'd0);
    tick();
    ResultSrcE = 2'b00; RdE = 0; Rs2D = 0;
    @(negedge clk);
    chk("lw_stall_cnt", stall_cnt, 32'd1);
    chk("lw_done", {31'b0, StallF}, 32'd0);
    tick();

    // Taken branch redirect
    PCSrcE = 1;
    @(negedge clk);
    chk("br_FlushD", {31'b0, FlushD}, 32'd1);
    chk("br_FlushE", {31'b0, FlushE}, 32'd1);
    chk("br_gate", {31'b0, PCSrcGate}, 32'd1);
    tick();
    PCSrcE = 0;
    @(negedge clk);
    chk("br_flush_cnt", flush_cnt, 32'd1);
    tick();

    // Memory wait of 3 cycles with a frozen branch in E
    MemReqM = 1; DmemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_StallF", {31'b0, StallF}, 32'd1);
      chk("mw_StallM", {31'b0, StallM}, 32'd1);
      chk("mw_FlushW", {31'b0, FlushW}, 32'd1);
      chk("mw_gate", {31'b0, PCSrcGate}, 32'd0);
      tick();
    end
    DmemReadyM = 1;
    @(negedge clk);
    chk("mw_rel_gate", {31'b0, PCSrcGate}, 32'd1);
    chk("mw_rel_FlushD", {31'b0, FlushD}, 32'd1);
    chk("mw_rel_StallE", {31'b0, StallE}, 32'd0);
    tick();
    MemReqM = 0; PCSrcE = 0;
    @(negedge clk);
    chk("mw_stall_cnt", stall_cnt, 32'd4);
    chk("mw_flush_cnt", flush_cnt, 32'd2);
    MemReqM = 1;
    #1 chk("mw_run_zero", {31'b0, StallF}, 32'd0);
    tick();
    MemReqM = 0;

    // Timeout into ERR, then reset recovery
    rst_n = 0;
    tick();
    rst_n = 1; MemReqM = 1; DmemReadyM = 0;
    for (int i = 0; i < MT; i++) begin
      @(negedge clk);
      chk("to_pre_err", {31'b0, mem_err}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("to_err", {31'b0, mem_err}, 32'd1);
    chk("to_err_stall", {31'b0, StallF}, 32'd1);
    tick();
    MemReqM = 0; DmemReadyM = 1;
    @(negedge clk);
    chk("to_sticky", {31'b0, mem_err}, 32'd1);
    chk("to_err_forever", {31'b0, StallE}, 32'd1);
    chk("to_stall_cnt", stall_cnt, 32'd5);
    rst_n = 0; PCSrcE = 1;
    #1 chk("rst_StallF_low", {31'b0, StallF}, 32'd0);
    chk("rst_gate_low", {31'b0, PCSrcGate}, 32'd0);
    chk("rst_FlushW_low", {31'b0, FlushW}, 32'd0);
    tick();
    rst_n = 1; PCSrcE = 0;
    @(negedge clk);
    chk("rec_mem_err", {31'b0, mem_err}, 32'd0);
    chk("rec_stall_cnt", stall_cnt, 32'd0);
    chk("rec_flush_cnt", flush_cnt, 32'd0);
    chk("rec_run", {31'b0, StallF}, 32'd0);
    tick();

    // Reset while in WAIT
    MemReqM = 1; DmemReadyM = 0;
    tick();
    MemReqM = 0;
    @(negedge clk);
    chk("w_in_wait", {31'b0, StallF}, 32'd1);
    rst_n = 0;
    #1 chk("w_rst_StallF", {31'b0, StallF}, 32'd0);
    chk("w_rst_StallE", {31'b0, StallE}, 32'd0);
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("w_back_run", {31'b0, StallF}, 32'd0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
